// File: rtl/keypad_pkg.sv
// Shared encodings for the 4x3 keypad scanner: FSM states, matrix geometry
// and the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;

    // Digits use their own value as code; the two symbol keys sit above 9.
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // Row-major position 0..11 maps to 1..9, *, 0, #.
    function automatic logic [3:0] key_code(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col);
        logic [3:0] idx;
        idx = {2'b00, row} * 4'd3 + {2'b00, col};
        case (idx)
            4'd9:    key_code = KEY_STAR;
            4'd10:   key_code = 4'd0;
            4'd11:   key_code = KEY_HASH;
            default: key_code = idx + 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to RESET_VAL.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the rows, debounces one key at a time and
// presents it as a one-hot digit or the start/clear strobes while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [9:0]          keypad,
    output logic                startn,
    output logic                clearn,
    output logic                key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_COLS-1:0] col_sync;

    state_t            state_reg, state_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [COL_W-1:0]  col_reg, col_next;
    logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [DEB_W-1:0]  deb_cnt_reg, deb_cnt_next;
    logic [9:0]        keypad_reg, keypad_next;
    logic              startn_reg, startn_next;
    logic              clearn_reg, clearn_next;
    logic              key_valid_reg, key_valid_next;

    logic              col_low;
    logic [COL_W-1:0]  first_col;
    logic [DEB_W-1:0]  deb_inc;
    logic [3:0]        code;

    sync2 #(.WIDTH(NUM_COLS), .RESET_VAL('1)) u_col_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (col_n),
        .q      (col_sync)
    );

    assign col_low = ~col_sync[col_reg];
    assign code    = key_code(row_reg, col_reg);
    assign deb_inc = (deb_cnt_reg == DEB_LAST) ? deb_cnt_reg : deb_cnt_reg + 1'b1;

    always_comb begin
        first_col = 2'd2;
        if (!col_sync[0])      first_col = 2'd0;
        else if (!col_sync[1]) first_col = 2'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= SCAN;
            row_reg       <= '0;
            col_reg       <= '0;
            div_cnt_reg   <= '0;
            deb_cnt_reg   <= '0;
            keypad_reg    <= '0;
            startn_reg    <= 1'b1;
            clearn_reg    <= 1'b1;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            div_cnt_reg   <= div_cnt_next;
            deb_cnt_reg   <= deb_cnt_next;
            keypad_reg    <= keypad_next;
            startn_reg    <= startn_next;
            clearn_reg    <= clearn_next;
            key_valid_reg <= key_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        div_cnt_next   = div_cnt_reg;
        deb_cnt_next   = deb_cnt_reg;
        keypad_next    = keypad_reg;
        startn_next    = startn_reg;
        clearn_next    = clearn_reg;
        key_valid_next = key_valid_reg;

        case (state_reg)
            SCAN: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (&col_sync) begin
                        row_next = row_reg + 1'b1;
                    end else begin
                        col_next     = first_col;
                        deb_cnt_next = '0;
                        state_next   = DEBOUNCE;
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!col_low) begin
                    deb_cnt_next = '0;
                    row_next     = row_reg + 1'b1;
                    state_next   = SCAN;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_next   = '0;
                    state_next     = PRESSED;
                    key_valid_next = 1'b1;
                    if (code == KEY_HASH)      startn_next = 1'b0;
                    else if (code == KEY_STAR) clearn_next = 1'b0;
                    else                       keypad_next = 10'b1 << code;
                end else begin
                    deb_cnt_next = deb_inc;
                end
            end
            PRESSED: begin
                if (!col_low) begin
                    deb_cnt_next = '0;
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                // A bounce back to low restarts the release count but keeps the key.
                if (col_low) begin
                    deb_cnt_next = '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_cnt_next   = '0;
                    row_next       = row_reg + 1'b1;
                    state_next     = SCAN;
                    keypad_next    = '0;
                    startn_next    = 1'b1;
                    clearn_next    = 1'b1;
                    key_valid_next = 1'b0;
                end else begin
                    deb_cnt_next = deb_inc;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row_drive
        assign row_n[gi] = (row_reg != ROW_W'(gi));
    end

    assign keypad    = keypad_reg;
    assign startn    = startn_reg;
    assign clearn    = clearn_reg;
    assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=8) with a
// behavioural switch matrix driving col_n from row_n and a held-key mask.
module tb_keypad_scanner;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       clearn;
    logic       key_valid;

    // Bit index = row*3 + col: '1'=0 '3'=2 '5'=4 '7'=6 '9'=8 '*'=9 '0'=10 '#'=11
    logic [11:0] held = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .col_n     (col_n),
        .row_n     (row_n),
        .keypad    (keypad),
        .startn    (startn),
        .clearn    (clearn),
        .key_valid (key_valid)
    );

    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 3; c++)
                    if (held[r*3+c]) col_n[c] = 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(input logic want, input int limit, output logic done);
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (key_valid === want) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        held   = '0;
        resetn = 1'b0;
        tick(3);
        n_cmp++; if (row_n !== 4'b1110) begin n_err++; $display("FAIL reset_row_n: got %b want 1110", row_n); end
        n_cmp++; if (keypad !== 10'b0) begin n_err++; $display("FAIL reset_keypad: got %b want 0", keypad); end
        n_cmp++; if (startn !== 1'b1) begin n_err++; $display("FAIL reset_startn: got %b want 1", startn); end
        n_cmp++; if (clearn !== 1'b1) begin n_err++; $display("FAIL reset_clearn: got %b want 1", clearn); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        $display("reset: row_n=%b keypad=%b startn=%b clearn=%b key_valid=%b", row_n, keypad, startn, clearn, key_valid);
        @(negedge clock) resetn = 1'b1;
    endtask

    task automatic test_idle_scan;
        logic [3:0] exp_row;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            n_cmp++;
            if (row_n !== exp_row) begin
                n_err++; $display("FAIL idle_row cycle %0d: got %b want %b", k, row_n, exp_row);
            end
            n_cmp++;
            if ({keypad, startn, clearn, key_valid} !== {10'b0, 1'b1, 1'b1, 1'b0}) begin
                n_err++; $display("FAIL idle_outputs cycle %0d: got keypad=%b startn=%b clearn=%b valid=%b want idle",
                                  k, keypad, startn, clearn, key_valid);
            end
        end
        $display("idle_scan: 20 cycles of row walk checked");
    endtask

    task automatic test_key5;
        logic early;
        logic done;
        held[4] = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (key_valid !== 1'b0) early = 1'b1;
        end
        n_cmp++; if (early) begin n_err++; $display("FAIL key5_early: key_valid rose within 10 cycles, want 0"); end
        wait_valid(1'b1, 100, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL key5_timeout: key_valid=%b want 1", key_valid); end
        n_cmp++; if (keypad !== 10'b0000100000) begin n_err++; $display("FAIL key5_keypad: got %b want 0000100000", keypad); end
        n_cmp++; if ({startn, clearn} !== 2'b11) begin n_err++; $display("FAIL key5_strobes: got %b want 11", {startn, clearn}); end
        $display("key5 press: keypad=%b key_valid=%b", keypad, key_valid);
        held = '0;
        tick(10);
        n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL key5_release_early: key_valid=%b want 1", key_valid); end
        tick(1);
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL key5_release: key_valid=%b want 0", key_valid); end
        n_cmp++; if (keypad !== 10'b0) begin n_err++; $display("FAIL key5_release_keypad: got %b want 0", keypad); end
        n_cmp++; if (row_n !== 4'b1011) begin n_err++; $display("FAIL key5_next_row: got %b want 1011", row_n); end
        $display("key5 release: keypad=%b key_valid=%b row_n=%b", keypad, key_valid, row_n);
    endtask

    task automatic test_bounce9;
        logic found;
        logic quiet;
        logic done;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (row_n !== 4'b1011) found = 1'b1;
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (row_n === 4'b1011) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_err++; $display("FAIL bounce9_row2: row_n=%b want 1011 within 40 cycles", row_n); end
        quiet = 1'b1;
        held[8] = 1'b1;
        tick(3);
        if (key_valid !== 1'b0) quiet = 1'b0;
        held[8] = 1'b0;
        tick(1);
        if (key_valid !== 1'b0) quiet = 1'b0;
        held[8] = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tick(1);
            if (key_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_err++; $display("FAIL bounce9_quiet: output asserted during bounce, want 0"); end
        wait_valid(1'b1, 40, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL bounce9_timeout: key_valid=%b want 1", key_valid); end
        n_cmp++; if (keypad !== 10'b1000000000) begin n_err++; $display("FAIL bounce9_keypad: got %b want 1000000000", keypad); end
        $display("bounce9: keypad=%b key_valid=%b", keypad, key_valid);
        held = '0;
        wait_valid(1'b0, 100, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL bounce9_release: key_valid=%b want 0", key_valid); end
    endtask

    task automatic test_hash_star;
        logic done;
        held[11] = 1'b1;
        wait_valid(1'b1, 100, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL hash_timeout: key_valid=%b want 1", key_valid); end
        n_cmp++; if ({keypad, startn, clearn} !== {10'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL hash_outputs: got keypad=%b startn=%b clearn=%b want 0/0/1", keypad, startn, clearn);
        end
        $display("hash: keypad=%b startn=%b clearn=%b", keypad, startn, clearn);
        held = '0;
        wait_valid(1'b0, 100, done);
        n_cmp++; if (startn !== 1'b1) begin n_err++; $display("FAIL hash_release: startn=%b want 1", startn); end
        held[9] = 1'b1;
        wait_valid(1'b1, 100, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL star_timeout: key_valid=%b want 1", key_valid); end
        n_cmp++; if ({keypad, startn, clearn} !== {10'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL star_outputs: got keypad=%b startn=%b clearn=%b want 0/1/0", keypad, startn, clearn);
        end
        $display("star: keypad=%b startn=%b clearn=%b", keypad, startn, clearn);
        held = '0;
        wait_valid(1'b0, 100, done);
        n_cmp++; if (clearn !== 1'b1) begin n_err++; $display("FAIL star_release: clearn=%b want 1", clearn); end
    endtask

    task automatic test_multi;
        logic done;
        held[0] = 1'b1;
        held[2] = 1'b1;
        wait_valid(1'b1, 100, done);
        n_cmp++; if (keypad !== 10'b0000000010) begin n_err++; $display("FAIL multi_lowest_col: got %b want 0000000010", keypad); end
        held[10] = 1'b1;
        tick(40);
        n_cmp++; if ({keypad, startn, clearn, key_valid} !== {10'b0000000010, 1'b1, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL multi_second_key: got keypad=%b startn=%b clearn=%b valid=%b want key 1 only",
                              keypad, startn, clearn, key_valid);
        end
        $display("multi: keypad=%b key_valid=%b", keypad, key_valid);
        held = '0;
        wait_valid(1'b0, 100, done);
        n_cmp++; if (keypad !== 10'b0) begin n_err++; $display("FAIL multi_release: got %b want 0", keypad); end
    endtask

    task automatic test_reset_mid;
        logic done;
        logic quiet;
        held[6] = 1'b1;
        wait_valid(1'b1, 100, done);
        n_cmp++; if (keypad !== 10'b0010000000) begin n_err++; $display("FAIL rst7_press: got %b want 0010000000", keypad); end
        #3 resetn = 1'b0;
        #1;
        n_cmp++; if (keypad !== 10'b0) begin n_err++; $display("FAIL rst7_async_keypad: got %b want 0", keypad); end
        n_cmp++; if (row_n !== 4'b1110) begin n_err++; $display("FAIL rst7_async_row: got %b want 1110", row_n); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL rst7_async_valid: got %b want 0", key_valid); end
        $display("reset mid-press: keypad=%b row_n=%b", keypad, row_n);
        @(negedge clock) resetn = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick(1);
            if (key_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (!quiet) begin n_err++; $display("FAIL rst7_redebounce: key_valid rose before full scan+debounce"); end
        tick(1);
        n_cmp++; if (keypad !== 10'b0010000000) begin n_err++; $display("FAIL rst7_repress: got %b want 0010000000", keypad); end
        $display("reset mid-press recovery: keypad=%b key_valid=%b", keypad, key_valid);
        held = '0;
        wait_valid(1'b0, 100, done);
        n_cmp++; if (!done) begin n_err++; $display("FAIL rst7_release: key_valid=%b want 0", key_valid); end
    endtask

    initial begin
        test_reset;
        test_idle_scan;
        test_key5;
        test_bounce9;
        test_hash_star;
        test_multi;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
